mips_cpu_div_unit: RTL
======================

// Module: mips_cpu_div_unit
// PURPOSE
//  Parametrised iterative restoring divider for MIPS DIV/DIVU; successor to the fixed 32-bit unsigned divider.
//  Adds WIDTH parameter, signed mode with MIPS truncation semantics, busy/done handshake, ignore-while-busy.
//  Sits beside the ALU; HI/LO control launches it and consumes Quotient (LO) and Remainder (HI) when done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      launch request; sampled only when busy=0
//  is_signed  in   1      1=DIV (two's complement), 0=DIVU; latched at launch
//  Dividend   in   WIDTH  latched at launch
//  Divisor    in   WIDTH  latched at launch
//  busy       out  1      operation in progress; start ignored while high
//  done       out  1      results valid; held until next accepted start or reset
//  Quotient   out  WIDTH  quotient
//  Remainder  out  WIDTH  remainder
//  dbz        out  1      divide-by-zero flag for the completed op; held with done
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, dbz=0, Quotient=0, Remainder=0; any op in flight is aborted.
//  States (enum from pkg): IDLE, CALC, FIX, DONE.
//  Launch: at a clk edge with start=1 and busy=0 (state IDLE or DONE):
//   - Divisor==0: -> DONE; done=1, dbz=1, Quotient=all-ones, Remainder=Dividend (1-edge latency).
//   - else: latch operands; magnitudes |a|,|b| when is_signed (unsigned when not); record neg_q=sa^sb, neg_r=sa;
//     done=0, dbz=0, busy=1, count=0, acc=0, -> CALC.
//  CALC: one restoring step per edge: {acc,q}<<1 takes next dividend MSB; if acc>=|b| subtract, q LSB=1.
//   acc is WIDTH+1 bits so acc>=|b| never overflows. After WIDTH steps (count==WIDTH-1) -> FIX.
//  FIX: Quotient = neg_q ? -q : q; Remainder = neg_r ? -acc : acc (low WIDTH bits); -> DONE, busy=0, done=1.
//  Latency: done high after exactly WIDTH+2 edges from launch edge (34 at WIDTH=32); busy high for WIDTH+1 edges.
//  Signed semantics: quotient truncates toward zero; remainder sign follows dividend; |R|<|Divisor|.
//  Overflow: MIN/-1 -> Quotient=MIN, Remainder=0, dbz=0 (falls out of magnitude path, no special case).
//  Dividend==0 takes the normal path (no shortcut); result 0/0, full latency.
//  start while busy: ignored, no effect on state or latched operands.
//  start in DONE: accepted; done drops the next edge (or stays 1 on dbz relaunch with new outputs).
//  Quotient/Remainder/dbz change only at FIX, dbz launch, or reset; stable during CALC.
//  Unsigned mode: operands are never negated; MSB is magnitude.
// STRUCTURE
//  Package mips_cpu_div_pkg: div_state_t enum {IDLE,CALC,FIX,DONE}; localparam helper for counter width
//   $clog2(WIDTH)+1.
//  Sub-module mips_cpu_div_step #(WIDTH): combinational restoring step (acc,q,divisor -> acc_next,q_next).
//  Top holds FSM, counter, sign bookkeeping, output registers.
// TESTING
//  DIVU 100/7 (WIDTH=32) -> Q=14, R=2, dbz=0; done exactly 34 edges after launch; busy 33 edges.
//  DIV -7/2 -> Q=-3 (0xFFFFFFFD), R=-1; DIV 7/-2 -> Q=-3, R=1; DIVU 0xFFFFFFF9/2 -> Q=0x7FFFFFFC, R=1.
//  Divisor=0, Dividend=0x1234 -> next edge done=1, dbz=1, Q=0xFFFFFFFF, R=0x1234; next launch 9/3 clears dbz.
//  DIV 0x80000000/-1 -> Q=0x80000000, R=0, dbz=0; DIVU 0x80000000/1 -> Q=0x80000000, R=0.
//  Launch 100/7, pulse start with 50/5 at edge 10 (ignored) -> still Q=14, R=2; reset at edge 20 -> all outputs 0,
//   busy=0; relaunch 50/5 -> Q=10, R=0.
//  WIDTH=8: DIV -128/3 -> Q=-42 (0xD6), R=-2 (0xFE), done after 10 edges; random signed/unsigned vs model.

Source files
------------

// File: rtl/mips_cpu_div_pkg.sv
// Shared types and sizing helpers for the iterative MIPS DIV/DIVU unit.
package mips_cpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Step counter must hold WIDTH-1; one spare bit keeps non-power-of-two widths safe.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division step: shift {acc,q} left, subtract divisor if it fits.
module mips_cpu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   acc_next_c,
  output logic [WIDTH-1:0] q_next_c
);

  logic [WIDTH:0] shifted_c;
  logic [WIDTH:0] diff_c;
  logic [WIDTH:0] divisor_ext_c;
  // acc stays below the divisor between steps, so its top bit is always zero here.
  logic           acc_msb_unused;

  assign acc_msb_unused = acc[WIDTH];
  assign shifted_c      = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign divisor_ext_c  = {1'b0, divisor};
  assign diff_c         = shifted_c - divisor_ext_c;

  always_comb begin
    acc_next_c = shifted_c;
    q_next_c   = {q[WIDTH-2:0], 1'b0};
    if (shifted_c >= divisor_ext_c) begin
      acc_next_c  = diff_c;
      q_next_c[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: magnitude datapath plus sign fix-up,
// busy/done handshake, divide-by-zero shortcut.
module mips_cpu_div_unit
  import mips_cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             dbz
);

  localparam int unsigned   CW   = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] bmag;
  logic             neg_q;
  logic             neg_r;

  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] amag_c;
  logic [WIDTH-1:0] bmag_c;
  logic [WIDTH:0]   acc_step_c;
  logic [WIDTH-1:0] q_step_c;

  // Operand magnitudes; MIN negates to itself, which is the correct unsigned magnitude.
  assign sa_c   = is_signed & Dividend[WIDTH-1];
  assign sb_c   = is_signed & Divisor[WIDTH-1];
  assign amag_c = sa_c ? -Dividend : Dividend;
  assign bmag_c = sb_c ? -Divisor  : Divisor;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .q          (q),
    .divisor    (bmag),
    .acc_next_c (acc_step_c),
    .q_next_c   (q_step_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      q         <= '0;
      bmag      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Dividend;
              done      <= 1'b1;
              dbz       <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= '0;
              q     <= amag_c;
              bmag  <= bmag_c;
              neg_q <= sa_c ^ sb_c;
              neg_r <= sa_c;
              count <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              dbz   <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= acc_step_c;
          q     <= q_step_c;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          Quotient  <= neg_q ? -q : q;
          Remainder <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
